// File: rtl/wb_regfile.sv
// wb_regfile: write-back pipeline register, 2**ADDR_W x DATA_W register file
// with two combinational read ports, and a counter of retired register writes.
//
// Optional feature: define RF_BYPASS_EN to forward EX and WB results to the read
// ports. Without it, reads return only the array contents.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   stall_i, flush_i       hold / kill the write-back register (flush wins)
//   ex_wdata_i/wd_i/wreg_i result triple from EX
//   re1_i/raddr1_i/rdata1_o  read port 1 (combinational)
//   re2_i/raddr2_i/rdata2_o  read port 2 (combinational)
//   wb_wdata_o/wd_o/wreg_o write-back register contents, exported for forwarding
//   retire_cnt_o           count of committed register writes, wraps at 2**32
module wb_regfile #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [DATA_W-1:0] ex_wdata_i,
  input  logic [ADDR_W-1:0] ex_wd_i,
  input  logic              ex_wreg_i,
  input  logic              re1_i,
  input  logic [ADDR_W-1:0] raddr1_i,
  input  logic              re2_i,
  input  logic [ADDR_W-1:0] raddr2_i,
  output logic [DATA_W-1:0] rdata1_o,
  output logic [DATA_W-1:0] rdata2_o,
  output logic [DATA_W-1:0] wb_wdata_o,
  output logic [ADDR_W-1:0] wb_wd_o,
  output logic              wb_wreg_o,
  output logic [31:0]       retire_cnt_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned CNT_W = 32;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [CNT_W-1:0]  retire_cnt;
  logic              commit_c;

  // The WB register holds a real register write (r0 writes are discarded).
  assign commit_c = wb_wreg_o && (wb_wd_o != '0);

  // Write-back pipeline register: flush beats stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_wdata_o <= '0;
      wb_wd_o    <= '0;
      wb_wreg_o  <= 1'b0;
    end else if (flush_i) begin
      wb_wdata_o <= '0;
      wb_wd_o    <= '0;
      wb_wreg_o  <= 1'b0;
    end else if (!stall_i) begin
      wb_wdata_o <= ex_wdata_i;
      wb_wd_o    <= ex_wd_i;
      wb_wreg_o  <= ex_wreg_i;
    end
  end

  // Register file commit; rewriting the same value while stalled is harmless.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (commit_c) begin
      mem[wb_wd_o] <= wb_wdata_o;
    end
  end

  // Count an instruction only when it leaves the stage, so a stall counts once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_cnt <= '0;
    end else if (commit_c && (!stall_i || flush_i)) begin
      retire_cnt <= retire_cnt + CNT_W'(1);
    end
  end

  assign retire_cnt_o = retire_cnt;

  // Read ports share one lookup structure.
  logic              re_v    [2];
  logic [ADDR_W-1:0] raddr_v [2];
  logic [DATA_W-1:0] rdata_v [2];

  assign re_v[0]    = re1_i;
  assign re_v[1]    = re2_i;
  assign raddr_v[0] = raddr1_i;
  assign raddr_v[1] = raddr2_i;
  assign rdata1_o   = rdata_v[0];
  assign rdata2_o   = rdata_v[1];

  for (genvar p = 0; p < 2; p++) begin : g_rd
    always_comb begin
      rdata_v[p] = '0;
      if (re_v[p] && (raddr_v[p] != '0)) begin
`ifdef RF_BYPASS_EN
        // Youngest producer first: EX, then WB, then the array.
        if (ex_wreg_i && (ex_wd_i == raddr_v[p])) begin
          rdata_v[p] = ex_wdata_i;
        end else if (wb_wreg_o && (wb_wd_o == raddr_v[p])) begin
          rdata_v[p] = wb_wdata_o;
        end else begin
          rdata_v[p] = mem[raddr_v[p]];
        end
`else
        rdata_v[p] = mem[raddr_v[p]];
`endif
      end
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile. Expected values are hand-computed;
// bypass-dependent expectations follow RF_BYPASS_EN.
module tb_wb_regfile;

  logic        clk;
  logic        rst_n;
  logic        stall_i, flush_i;
  logic [31:0] ex_wdata_i;
  logic [4:0]  ex_wd_i;
  logic        ex_wreg_i;
  logic        re1_i, re2_i;
  logic [4:0]  raddr1_i, raddr2_i;
  logic [31:0] rdata1_o, rdata2_o;
  logic [31:0] wb_wdata_o;
  logic [4:0]  wb_wd_o;
  logic        wb_wreg_o;
  logic [31:0] retire_cnt_o;

  int checks = 0;
  int errors = 0;

`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  wb_regfile dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall_i      (stall_i),
    .flush_i      (flush_i),
    .ex_wdata_i   (ex_wdata_i),
    .ex_wd_i      (ex_wd_i),
    .ex_wreg_i    (ex_wreg_i),
    .re1_i        (re1_i),
    .raddr1_i     (raddr1_i),
    .re2_i        (re2_i),
    .raddr2_i     (raddr2_i),
    .rdata1_o     (rdata1_o),
    .rdata2_o     (rdata2_o),
    .wb_wdata_o   (wb_wdata_o),
    .wb_wd_o      (wb_wd_o),
    .wb_wreg_o    (wb_wreg_o),
    .retire_cnt_o (retire_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ex(input logic w, input logic [4:0] wd, input logic [31:0] d);
    ex_wreg_i  = w;
    ex_wd_i    = wd;
    ex_wdata_i = d;
  endtask

  initial begin
    rst_n = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
    drive_ex(1'b0, 5'd0, 32'h0);
    re1_i = 1'b1; raddr1_i = 5'd5; re2_i = 1'b0; raddr2_i = 5'd0;
    #2;
    // Reset state
    chk("rst_wreg", 32'(wb_wreg_o), 32'h0);
    chk("rst_wd", 32'(wb_wd_o), 32'h0);
    chk("rst_wdata", wb_wdata_o, 32'h0);
    chk("rst_cnt", retire_cnt_o, 32'h0);
    chk("rst_rd5", rdata1_o, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Basic commit to r3
    drive_ex(1'b1, 5'd3, 32'h1234ABCD);
    tick();
    chk("cap_wd", 32'(wb_wd_o), 32'd3);
    chk("cap_wreg", 32'(wb_wreg_o), 32'd1);
    chk("cap_wdata", wb_wdata_o, 32'h1234ABCD);
    drive_ex(1'b0, 5'd0, 32'h0);
    raddr1_i = 5'd3;
    tick();
    chk("commit_rd3", rdata1_o, 32'h1234ABCD);
    chk("commit_cnt", retire_cnt_o, 32'd1);

    // r0 protection
    drive_ex(1'b1, 5'd0, 32'hFFFFFFFF);
    tick();
    drive_ex(1'b0, 5'd0, 32'h0);
    re2_i = 1'b1; raddr2_i = 5'd0;
    #1 chk("r0_rd_wb", rdata2_o, 32'h0);
    tick();
    chk("r0_rd", rdata2_o, 32'h0);
    chk("r0_cnt", retire_cnt_o, 32'd1);

    // Stall holds WB for 3 cycles and retires once
    drive_ex(1'b1, 5'd7, 32'h000000AA);
    tick();
    stall_i = 1'b1;
    drive_ex(1'b1, 5'd8, 32'h00000055);
    tick();
    chk("stall_cnt1", retire_cnt_o, 32'd1);
    tick();
    tick();
    chk("stall_wd", 32'(wb_wd_o), 32'd7);
    chk("stall_wdata", wb_wdata_o, 32'h000000AA);
    chk("stall_wreg", 32'(wb_wreg_o), 32'd1);
    chk("stall_cnt3", retire_cnt_o, 32'd1);
    stall_i = 1'b0;
    drive_ex(1'b0, 5'd0, 32'h0);
    raddr2_i = 5'd7;
    tick();
    chk("stall_rel_cnt", retire_cnt_o, 32'd2);
    chk("stall_rd7", rdata2_o, 32'h000000AA);

    // Flush beats stall; the instruction in WB still commits and retires
    drive_ex(1'b1, 5'd10, 32'h00000010);
    tick();
    drive_ex(1'b1, 5'd9, 32'h00000099);
    stall_i = 1'b1; flush_i = 1'b1;
    tick();
    chk("flush_wreg", 32'(wb_wreg_o), 32'd0);
    chk("flush_wd", 32'(wb_wd_o), 32'd0);
    chk("flush_wdata", wb_wdata_o, 32'h0);
    chk("flush_cnt", retire_cnt_o, 32'd3);
    stall_i = 1'b0; flush_i = 1'b0;
    drive_ex(1'b0, 5'd0, 32'h0);
    raddr1_i = 5'd9; raddr2_i = 5'd10;
    tick();
    chk("flush_rd9", rdata1_o, 32'h0);
    chk("flush_rd10", rdata2_o, 32'h00000010);
    chk("flush_cnt2", retire_cnt_o, 32'd3);

    // Bypass: r4 = 0x11 in the array, then 0x22 in flight
    drive_ex(1'b1, 5'd4, 32'h00000011);
    tick();
    drive_ex(1'b0, 5'd0, 32'h0);
    tick();
    drive_ex(1'b1, 5'd4, 32'h00000022);
    raddr1_i = 5'd4; raddr2_i = 5'd6;
    #1 chk("byp_ex", rdata1_o, BYP ? 32'h00000022 : 32'h00000011);
    tick();
    drive_ex(1'b1, 5'd6, 32'h00000066);
    #1 chk("byp_wb", rdata1_o, BYP ? 32'h00000022 : 32'h00000011);
    chk("byp_ex6", rdata2_o, BYP ? 32'h00000066 : 32'h0);
    tick();
    drive_ex(1'b0, 5'd0, 32'h0);
    #1 chk("byp_arr4", rdata1_o, 32'h00000022);
    chk("byp_wb6", rdata2_o, BYP ? 32'h00000066 : 32'h0);
    re1_i = 1'b0;
    #1 chk("re_off", rdata1_o, 32'h0);
    re1_i = 1'b1;
    tick();
    chk("byp_cnt", retire_cnt_o, 32'd6);
    chk("byp_arr6", rdata2_o, 32'h00000066);

    // Counter wrap via preload
    @(negedge clk);
    force dut.retire_cnt = 32'hFFFFFFFF;
    #1 release dut.retire_cnt;
    drive_ex(1'b1, 5'd12, 32'h00000001);
    tick();
    chk("wrap_pre", retire_cnt_o, 32'hFFFFFFFF);
    drive_ex(1'b0, 5'd0, 32'h0);
    tick();
    chk("wrap_cnt", retire_cnt_o, 32'h0);

    // Asynchronous reset mid-cycle with a write pending in WB
    drive_ex(1'b1, 5'd13, 32'h00000013);
    raddr1_i = 5'd3; raddr2_i = 5'd12;
    tick();
    chk("pre_rst_wreg", 32'(wb_wreg_o), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_wreg", 32'(wb_wreg_o), 32'd0);
    chk("arst_wd", 32'(wb_wd_o), 32'd0);
    chk("arst_wdata", wb_wdata_o, 32'h0);
    chk("arst_cnt", retire_cnt_o, 32'h0);
    chk("arst_rd3", rdata1_o, 32'h0);
    chk("arst_rd12", rdata2_o, 32'h0);
    drive_ex(1'b0, 5'd0, 32'h0);
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    raddr1_i = 5'd13;
    #1 chk("post_rst_rd13", rdata1_o, 32'h0);
    chk("post_rst_cnt", retire_cnt_o, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
